channel_pattern_player: RTL and testbench
=========================================

CHANNEL_PATTERN_PLAYER -- requirements
Module: channel_pattern_player

Interface
REQ-001 SHALL have parameter NUMBER_OF_CHANNELS, default 7, the number of serial output channels.
REQ-002 SHALL have parameter NUMBER_OF_BITS, default 8, the bits per sample byte.
REQ-003 SHALL have parameter SAMPLES_BUFFER_SIZE, default 10, the bytes stored per channel; BUFFER_SIZE = NUMBER_OF_BITS*SAMPLES_BUFFER_SIZE (80).
REQ-004 SHALL have parameter CLK_DIV, default 1, the clocks per output bit (1..255).
REQ-005 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port ena, input, 1; when low, all state holds.
REQ-008 SHALL have port ui_in, input, 8, the write data byte.
REQ-009 SHALL have port uio_in, input, 8: [2:0] chan_sel, [3] wr, [4] start, [5] stop, [7:6] unused.
REQ-010 SHALL have port uo_out, output, 8: [6:0] channel serial data, [7] frame sync.
REQ-011 SHALL have port uio_out, output, 8: [7] busy, [6] done, [5:0] constant 0.
REQ-012 SHALL have port uio_oe, output, 8, constant 8'hC0.

Function
REQ-013 SHALL register wr, start and stop once and act only on rising edges (current 1, previous 0).
REQ-014 SHALL, on a wr edge in IDLE/DONE with chan_sel<7, shift the selected buffer left by 8 and insert ui_in in bits [7:0]; the first-written byte ends up at [79:72] after 10 writes.
REQ-015 SHALL, on a wr edge with chan_sel=7, latch loop_mode = ui_in[0]; ui_in[7:1] ignored.
REQ-016 SHALL ignore wr edges in PLAY.
REQ-017 SHALL implement FSM IDLE, PLAY, DONE: IDLE/DONE -start-> PLAY; PLAY -80th bit ends, loop_mode=0-> DONE; any state -stop-> IDLE; DONE -wr-> IDLE.
REQ-018 SHALL, on the clock edge after a start edge is sampled, drive uo_out[c] = buffer[c][79] for all channels and uo_out[7] = 1.
REQ-019 SHALL hold each bit exactly CLK_DIV cycles, then rotate every buffer left by 1 and present the new MSB; uo_out[7] is 1 only during bit 0 of each pass.
REQ-020 SHALL rotate rather than shift, so buffer contents are identical before and after a full 80-bit pass.
REQ-021 SHALL, in loop mode, follow bit 79 directly with bit 0 of the next pass, with no gap cycles.
REQ-022 SHALL drive uo_out = 0 in IDLE and DONE; busy = (state==PLAY); done = (state==DONE).
REQ-023 SHALL make stop win over start when both edges occur in the same cycle; on stop, realign any buffer left mid-rotation to its original order before the next PLAY.
REQ-024 SHALL perform the write and ignore start when a wr edge and a start edge occur in the same cycle.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all buffers, loop_mode, edge registers, prescaler and bit counter, set state IDLE, and drive uo_out=0 and uio_out=0, including mid-PLAY.

Configuration
REQ-026 SHALL compile loop support only when PLAYER_LOOP_EN is defined; otherwise loop_mode is absent, chan_sel=7 writes are ignored, and every PLAY ends in DONE.

Structure
REQ-027 SHALL take channel/bit/buffer constants and the state enum from shared package player_pkg.
REQ-028 SHALL use sub-module bit_prescaler (CLK_DIV tick generator, cleared on PLAY entry).

Verification
REQ-029 SHALL cover: write 0xA5 then nine 0x00 to channel 0, start, CLK_DIV=1 -> uo_out[0] = 1,0,1,0,0,1,0,1 then 72 zeros; sync high on cycle 1 only; done=1 after 80 bits.
REQ-030 SHALL cover: CLK_DIV=3, channel 1 all 0xFF -> uo_out[1] high for 240 cycles, busy high for exactly 240 cycles.
REQ-031 SHALL cover: with PLAYER_LOOP_EN, loop=1, 200 bits, then stop -> sync every 80 bits, then uo_out=0 and state IDLE; a second start replays from byte 0.
REQ-032 SHALL cover: start and stop edges in the same cycle -> busy stays 0; a wr edge during PLAY -> buffer unchanged after DONE.
REQ-033 SHALL cover: rst_n low at bit 40 -> uo_out=0 immediately; after reset, start gives all-zero data.

Source files
------------

// File: rtl/player_pkg.sv
// Shared constants and state encoding for the channel pattern player.
package player_pkg;

  localparam int NUM_CH    = 7;
  localparam int NUM_BITS  = 8;
  localparam int SAMPLES   = 10;
  localparam int BUF_BITS  = NUM_BITS * SAMPLES;

  // chan_sel value that addresses the loop-mode control register
  localparam logic [2:0] LOOP_SEL = 3'd7;
  // busy/done pins are outputs, the rest of the bidir bank stays input
  localparam logic [7:0] OE_MASK  = 8'hC0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_prescaler.sv
// Bit-period tick generator: one tick every CLK_DIV enabled clocks while
// running; restarted whenever playback is (re)entered or not running.
module bit_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  assign tick_o = run_i && (cnt_q == LAST);

  // Count clocks within the current bit, wrapping on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      if (clr_i || !run_i || tick_o) cnt_q <= '0;
      else                           cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/channel_pattern_player.sv
// Multi-channel serial pattern player: per-channel byte buffers are loaded
// over ui_in, then played out MSB-first in parallel with a frame sync on
// bit 0 of every pass. Buffers rotate, so contents survive playback.
// Optional feature: define PLAYER_LOOP_EN for continuous looping playback.
module channel_pattern_player
  import player_pkg::*;
#(
  parameter int NUMBER_OF_CHANNELS  = NUM_CH,
  parameter int NUMBER_OF_BITS      = NUM_BITS,
  parameter int SAMPLES_BUFFER_SIZE = SAMPLES,
  parameter int CLK_DIV             = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BUF = NUMBER_OF_BITS * SAMPLES_BUFFER_SIZE;
  localparam int CW  = $clog2(BUF);
  localparam int NB  = NUMBER_OF_BITS;

  // Right-rotate by n: undoes n single-bit left rotations
  function automatic logic [BUF-1:0] rotr(input logic [BUF-1:0] v,
                                          input logic [CW-1:0]  n);
    logic [2*BUF-1:0] w;
    w = {v, v} >> n;
    return w[BUF-1:0];
  endfunction

  logic                             wr_prev_q, start_prev_q, stop_prev_q;
  state_t                           state_q;
  logic [NUMBER_OF_CHANNELS-1:0][BUF-1:0] buf_q;
  logic [NUMBER_OF_CHANNELS-1:0][BUF-1:0] realign;
  logic [CW-1:0]                    bit_q;
  logic                             loop_active;

`ifdef PLAYER_LOOP_EN
  logic loop_q;
  assign loop_active = loop_q;
`else
  assign loop_active = 1'b0;
`endif

  logic [2:0] chan_sel;
  logic       wr_edge, start_edge, stop_edge;
  logic       play, tick, last_bit;
  logic       do_wr, do_start;
  logic       unused_ok;

  assign chan_sel   = uio_in[2:0];
  assign wr_edge    = uio_in[3] & ~wr_prev_q;
  assign start_edge = uio_in[4] & ~start_prev_q;
  assign stop_edge  = uio_in[5] & ~stop_prev_q;
  assign unused_ok  = &{1'b0, uio_in[7:6]};

  assign play     = (state_q == ST_PLAY);
  assign last_bit = (bit_q == CW'(BUF - 1));
  // stop beats everything; a write in the same cycle swallows a start
  assign do_wr    = wr_edge & ~play & ~stop_edge;
  assign do_start = start_edge & ~play & ~stop_edge & ~wr_edge;

  bit_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .clr_i  (do_start),
    .run_i  (play),
    .tick_o (tick)
  );

  // Undo a partial rotation so a stopped pass restarts from byte 0
  always_comb begin
    realign = buf_q;
    for (int c = 0; c < NUMBER_OF_CHANNELS; c++)
      realign[c] = rotr(buf_q[c], bit_q);
  end

  // Control FSM together with buffer load/rotate and edge capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q    <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      bit_q        <= '0;
`ifdef PLAYER_LOOP_EN
      loop_q       <= 1'b0;
`endif
    end else if (ena) begin
      wr_prev_q    <= uio_in[3];
      start_prev_q <= uio_in[4];
      stop_prev_q  <= uio_in[5];
      if (stop_edge) begin
        state_q <= ST_IDLE;
        bit_q   <= '0;
        if (play) buf_q <= realign;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (tick) begin
              for (int c = 0; c < NUMBER_OF_CHANNELS; c++)
                buf_q[c] <= {buf_q[c][BUF-2:0], buf_q[c][BUF-1]};
              if (last_bit) begin
                bit_q <= '0;
                if (!loop_active) state_q <= ST_DONE;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end
          default: begin
            if (do_wr) begin
              state_q <= ST_IDLE;
              if (int'(chan_sel) < NUMBER_OF_CHANNELS)
                buf_q[chan_sel] <= {buf_q[chan_sel][BUF-NB-1:0], ui_in[NB-1:0]};
`ifdef PLAYER_LOOP_EN
              else if (chan_sel == LOOP_SEL)
                loop_q <= ui_in[0];
`endif
            end else if (do_start) begin
              state_q <= ST_PLAY;
            end
          end
        endcase
      end
    end
  end

  // Present the current MSB of every buffer, sync on the first bit of a pass
  always_comb begin
    uo_out = '0;
    if (play) begin
      for (int c = 0; c < NUMBER_OF_CHANNELS; c++)
        uo_out[c] = buf_q[c][BUF-1];
      uo_out[7] = (bit_q == '0);
    end
  end

  assign uio_out = {play, (state_q == ST_DONE), 6'b000000};
  assign uio_oe  = OE_MASK;

endmodule

// File: tb/tb_channel_pattern_player.sv
// Directed bench for channel_pattern_player: two instances (CLK_DIV 1 and 3)
// share all inputs; expected values are hand-derived bit patterns.
module tb_channel_pattern_player;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo1, uio1, oe1;
  logic [7:0] uo3, uio3, oe3;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] pat;

  always #5 clk = ~clk;

  channel_pattern_player #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1));

  channel_pattern_player #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo3), .uio_out(uio3), .uio_oe(oe3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {4'b0000, 1'b1, ch};
    @(negedge clk);
    uio_in[3] = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    uio_in = m;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  // Called at the sample point showing bit 0 of a single (non-loop) pass on dut1
  task automatic play80(input string tag, input logic [7:0] b0, input logic [5:0] hi);
    logic eb;
    for (int i = 0; i < 80; i++) begin
      eb = (i < 8) ? b0[7-i] : 1'b0;
      chk({tag, "_ch0"}, uo1[0], eb);
      chk({tag, "_hi"}, uo1[6:1], hi);
      chk({tag, "_sync"}, uo1[7], (i == 0));
      chk({tag, "_busy"}, uio1[7], 1'b1);
      @(negedge clk);
    end
    chk({tag, "_done"}, uio1, 8'h40);
    chk({tag, "_idle_out"}, uo1, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat    = 8'hA5;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo1, 8'h00);
    chk("rst_uio", uio1, 8'h00);
    chk("rst_oe", oe1, 8'hC0);
    chk("rst_uo3", uo3, 8'h00);
    rst_n = 1'b1;

    // load ch0 = A5,00 x9 and ch1 = FF x10
    wr(3'd0, 8'hA5);
    for (int k = 0; k < 9; k++) wr(3'd0, 8'h00);
    for (int k = 0; k < 10; k++) wr(3'd1, 8'hFF);
    @(negedge clk);
    chk("pre_busy1", uio1, 8'h00);
    chk("pre_busy3", uio3, 8'h00);

    // single pass on both dividers
    pulse(8'h10);
    for (int i = 0; i < 240; i++) begin
      int b;
      b = i / 3;
      chk("d3_busy", uio3[7], 1'b1);
      chk("d3_ch1", uo3[1], 1'b1);
      chk("d3_ch0", uo3[0], (b < 8) ? pat[7-b] : 1'b0);
      chk("d3_sync", uo3[7], (i < 3));
      if (i < 80) begin
        chk("d1_ch0", uo1[0], (i < 8) ? pat[7-i] : 1'b0);
        chk("d1_ch1", uo1[1], 1'b1);
        chk("d1_sync", uo1[7], (i == 0));
        chk("d1_busy", uio1[7], 1'b1);
      end else if (i == 80) begin
        chk("d1_done", uio1, 8'h40);
        chk("d1_out0", uo1, 8'h00);
      end
      @(negedge clk);
    end
    chk("d3_done", uio3, 8'h40);
    chk("d3_out0", uo3, 8'h00);

    // start and stop together: stop wins
    pulse(8'h30);
    chk("ss_uio1", uio1, 8'h00);
    chk("ss_uio3", uio3, 8'h00);

    // write during PLAY is ignored
    pulse(8'h10);
    wr(3'd0, 8'hFF);
    for (int k = 0; k < 200; k++) begin
      if (uio1[6]) break;
      @(negedge clk);
    end
    chk("wrplay_done", uio1, 8'h40);
    pulse(8'h10);
    play80("wrplay", 8'hA5, 6'b000001);

    // loop enable (ignored when loop support is compiled out)
    wr(3'd7, 8'h01);
`ifdef PLAYER_LOOP_EN
    pulse(8'h10);
    for (int i = 0; i < 200; i++) begin
      int j;
      j = i % 80;
      chk("loop_ch0", uo1[0], (j < 8) ? pat[7-j] : 1'b0);
      chk("loop_sync", uo1[7], (j == 0));
      chk("loop_busy", uio1[7], 1'b1);
      @(negedge clk);
    end
    pulse(8'h20);
    chk("loop_stop_uo", uo1, 8'h00);
    chk("loop_stop_uio", uio1, 8'h00);
    wr(3'd7, 8'h00);
`endif
    pulse(8'h10);
    play80("noloop", 8'hA5, 6'b000001);

    // ena low freezes bit 0, then stop mid-pass and replay from byte 0
    pulse(8'h10);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_ch0", uo1[0], 1'b1);
      chk("hold_sync", uo1[7], 1'b1);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("resume_ch0", uo1[0], 1'b0);
    chk("resume_sync", uo1[7], 1'b0);
    repeat (30) @(negedge clk);
    pulse(8'h20);
    chk("stop_uo", uo1, 8'h00);
    chk("stop_uio", uio1, 8'h00);
    pulse(8'h10);
    play80("replay", 8'hA5, 6'b000001);

    // asynchronous reset at bit 40
    pulse(8'h10);
    repeat (40) @(negedge clk);
    chk("b40_busy", uio1[7], 1'b1);
    chk("b40_ch1", uo1[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uo", uo1, 8'h00);
    chk("arst_uio", uio1, 8'h00);
    chk("arst_uo3", uo3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(8'h10);
    play80("postrst", 8'h00, 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
